// File: rtl/difftest_commit_arbiter.sv
// Round-robin arbiter sharing one difftest FIFO write port among NUM_SRC trace sources; optional stats via DIFFTEST_ARB_STATS_EN.
// Latency: handshake to registered FIFO write is 1 cycle, 1 record/cycle.
// Backpressure: ready drops same cycle on almost-full/full, stall_dut held >= MIN_STALL cycles, DRAIN sinks all traffic.
module difftest_commit_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 128,
  parameter int MIN_STALL = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        drain,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic                        fifo_almost_full,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [DATA_W-1:0]           fifo_wr_data,
  output logic [2:0]                  fifo_wr_src,
  output logic                        stall_dut,
  output logic [31:0]                 drop_count,
  output logic [1:0]                  debug_state
`ifdef DIFFTEST_ARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0]       grant_count,
  output logic [31:0]                 stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam int CNT_W = $clog2(MIN_STALL + 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(MIN_STALL);

  state_e              state_q, state_d;
  logic [2:0]          rr_ptr_q, rr_ptr_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_dat_q, wr_dat_d;
  logic [2:0]          wr_src_q, wr_src_d;
  logic                stall_q, stall_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [31:0]         drop_q, drop_d;

  // Records padded to 8 entries so a 3-bit index is always in range.
  logic [DATA_W-1:0]   rec [8];
  logic [7:0]          valid_ext;
  logic [3:0]          cand;
  logic [3:0]          pop;
  logic [3:0]          drop_inc;
  logic [32:0]         drop_sum;
  logic                grant_vld;
  logic [2:0]          grant_idx;
  logic                run_ok;
  logic                hs_fire;
  logic                stall_trig;

  for (genvar i = 0; i < 8; i++) begin : g_rec
    if (i < NUM_SRC) begin : g_used
      assign rec[i] = src_data[i*DATA_W +: DATA_W];
    end else begin : g_pad
      assign rec[i] = '0;
    end
  end

  assign valid_ext = 8'(src_valid);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (drain) state_d = S_DRAIN; else if (enable) state_d = S_RUN;
      S_RUN:   if (drain) state_d = S_DRAIN; else if (!enable) state_d = S_IDLE;
      S_DRAIN: state_d = S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + 4'(k);
      if (cand >= 4'(NUM_SRC)) cand = cand - 4'(NUM_SRC);
      if (!grant_vld && valid_ext[cand[2:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[2:0];
      end
    end
  end

  assign run_ok  = (state_q == S_RUN) && !fifo_almost_full && !fifo_full;
  assign hs_fire = run_ok && grant_vld;

  always_comb begin
    src_ready = '0;
    if (state_q == S_DRAIN) begin
      src_ready = '1;
    end else if (hs_fire) begin
      src_ready = NUM_SRC'(1) << grant_idx;
    end
  end

  // A handshake coinciding with drain is accepted but discarded.
  always_comb begin
    wr_en_d  = hs_fire && !drain;
    wr_dat_d = wr_dat_q;
    wr_src_d = wr_src_q;
    rr_ptr_d = rr_ptr_q;
    if (wr_en_d) begin
      wr_dat_d = rec[grant_idx];
      wr_src_d = grant_idx;
      rr_ptr_d = (grant_idx == 3'(NUM_SRC - 1)) ? 3'd0 : grant_idx + 3'd1;
    end
  end

  always_comb begin
    pop = '0;
    for (int k = 0; k < NUM_SRC; k++) pop = pop + {3'b000, src_valid[k]};
    drop_inc = '0;
    if (state_q == S_DRAIN) drop_inc = pop;
    else if (hs_fire && drain) drop_inc = 4'd1;
    drop_sum = {1'b0, drop_q} + {29'b0, drop_inc};
    drop_d   = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
  end

  assign stall_trig = (state_q == S_RUN) && fifo_almost_full && (|src_valid);

  always_comb begin
    stall_d     = stall_q;
    stall_cnt_d = stall_cnt_q;
    if (state_d == S_DRAIN) begin
      stall_d     = 1'b0;
      stall_cnt_d = '0;
    end else if (!stall_q) begin
      if (stall_trig) begin
        stall_d     = 1'b1;
        stall_cnt_d = CNT_W'(1);
      end
    end else if (stall_cnt_q == STALL_MAX) begin
      if (!fifo_almost_full) begin
        stall_d     = 1'b0;
        stall_cnt_d = '0;
      end
    end else begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_dat_q    <= '0;
      wr_src_q    <= '0;
      stall_q     <= 1'b0;
      stall_cnt_q <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      wr_en_q     <= wr_en_d;
      wr_dat_q    <= wr_dat_d;
      wr_src_q    <= wr_src_d;
      stall_q     <= stall_d;
      stall_cnt_q <= stall_cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_dat_q;
  assign fifo_wr_src  = wr_src_q;
  assign stall_dut    = stall_q;
  assign drop_count   = drop_q;
  assign debug_state  = state_q;

`ifdef DIFFTEST_ARB_STATS_EN
  logic [NUM_SRC*32-1:0] grant_cnt_q;
  logic [31:0]           stall_cyc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt_q <= '0;
      stall_cyc_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (hs_fire && grant_idx == 3'(i) && grant_cnt_q[i*32 +: 32] != 32'hFFFF_FFFF)
          grant_cnt_q[i*32 +: 32] <= grant_cnt_q[i*32 +: 32] + 32'd1;
      end
      if (stall_q && stall_cyc_q != 32'hFFFF_FFFF) stall_cyc_q <= stall_cyc_q + 32'd1;
    end
  end

  assign grant_count  = grant_cnt_q;
  assign stall_cycles = stall_cyc_q;
`endif

endmodule

// File: tb/tb_difftest_commit_arbiter.sv
// Bench for difftest_commit_arbiter: vector table, directed corner sequences, then random traffic against a reference model.
module tb_difftest_commit_arbiter;
  localparam int N  = 4;
  localparam int DW = 128;
  localparam int MS = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              drain;
  logic [N-1:0]      src_valid;
  logic [N*DW-1:0]   src_data;
  logic [N-1:0]      src_ready;
  logic              fifo_almost_full;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic [2:0]        fifo_wr_src;
  logic              stall_dut;
  logic [31:0]       drop_count;
  logic [1:0]        debug_state;
`ifdef DIFFTEST_ARB_STATS_EN
  logic [N*32-1:0]   grant_count;
  logic [31:0]       stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  difftest_commit_arbiter #(.NUM_SRC(N), .DATA_W(DW), .MIN_STALL(MS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .drain(drain),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .fifo_almost_full(fifo_almost_full), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_src(fifo_wr_src),
    .stall_dut(stall_dut), .drop_count(drop_count), .debug_state(debug_state)
`ifdef DIFFTEST_ARB_STATS_EN
    , .grant_count(grant_count), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       dr;
    logic [3:0] vld;
    logic       af;
    logic       full;
    logic [3:0] rdy;
    logic       wr;
    logic [2:0] src;
    logic [1:0] st;
  } vec_t;

  vec_t vecs [20];

  // Reference model state
  int          m_mode;
  int          m_ptr;
  bit          m_wr;
  logic [DW-1:0] m_wr_dat;
  int          m_wr_src;
  bit          m_stall;
  int          m_age;
  longint      m_drop;

  function automatic vec_t mk(input logic en, input logic dr, input logic [3:0] vld, input logic af,
                              input logic full, input logic [3:0] rdy, input logic wr,
                              input logic [2:0] src, input logic [1:0] st);
    vec_t v;
    v.en = en; v.dr = dr; v.vld = vld; v.af = af; v.full = full;
    v.rdy = rdy; v.wr = wr; v.src = src; v.st = st;
    return v;
  endfunction

  function automatic logic [DW-1:0] pat(input int s, input int tag);
    return {32'(tag), 32'hC0DE_0000 | 32'(s), ~32'(tag), 32'(s) * 32'h0101_0101};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_data(input int tag);
    for (int s = 0; s < N; s++) src_data[s*DW +: DW] = pat(s, tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; drain = 1'b0; src_valid = '0;
    fifo_almost_full = 1'b0; fifo_full = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic model_reset();
    m_mode = 0; m_ptr = 0; m_wr = 0; m_wr_dat = '0; m_wr_src = 0;
    m_stall = 0; m_age = 0; m_drop = 0;
  endtask

  // One cycle of the spec rules: returns the expected ready, advances the model across the edge.
  task automatic model_cycle(output logic [N-1:0] rdy);
    int g;
    int nmode;
    bit trig;
    g   = -1;
    rdy = '0;
    if (m_mode == 2) begin
      rdy = '1;
    end else if (m_mode == 1 && !fifo_almost_full && !fifo_full) begin
      for (int off = 0; off < N; off++)
        if (g < 0 && src_valid[(m_ptr + off) % N]) g = (m_ptr + off) % N;
      if (g >= 0) rdy[g] = 1'b1;
    end
    nmode = m_mode;
    if (drain) nmode = 2;
    else if (m_mode == 0 && enable) nmode = 1;
    else if (m_mode == 1 && !enable) nmode = 0;
    if (m_mode == 2) m_drop += $countones(src_valid);
    else if (g >= 0 && drain) m_drop += 1;
    if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
    m_wr = (g >= 0) && !drain;
    if (m_wr) begin
      m_wr_dat = src_data[g*DW +: DW];
      m_wr_src = g;
      m_ptr    = (g + 1) % N;
    end
    trig = (m_mode == 1) && fifo_almost_full && (src_valid != 0);
    if (nmode == 2) begin
      m_stall = 0; m_age = 0;
    end else if (!m_stall) begin
      if (trig) begin m_stall = 1; m_age = 1; end
    end else if (m_age >= MS) begin
      if (!fifo_almost_full) begin m_stall = 0; m_age = 0; end
    end else begin
      m_age++;
    end
    m_mode = nmode;
  endtask

  logic [N-1:0] exp_rdy;
  int  hi_cnt, wr_seen, hs_cyc, hs_tag;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b0; drain = 1'b0; src_valid = '0; src_data = '0;
    fifo_almost_full = 1'b0; fifo_full = 1'b0;
    #3;
    chk("rst_ready", 128'(src_ready), 128'(0));
    chk("rst_wr_en", 128'(fifo_wr_en), 128'(0));
    chk("rst_wr_data", fifo_wr_data, 128'(0));
    chk("rst_wr_src", 128'(fifo_wr_src), 128'(0));
    chk("rst_stall", 128'(stall_dut), 128'(0));
    chk("rst_drop", 128'(drop_count), 128'(0));
    chk("rst_state", 128'(debug_state), 128'(0));

    // ---------------- vector table: round-robin, skip/wrap, enable drop, full ----------------
    vecs[0]  = mk(1, 0, 4'b1111, 0, 0, 4'b0000, 0, 3'd0, 2'd1);
    vecs[1]  = mk(1, 0, 4'b1111, 0, 0, 4'b0001, 1, 3'd0, 2'd1);
    vecs[2]  = mk(1, 0, 4'b1111, 0, 0, 4'b0010, 1, 3'd1, 2'd1);
    vecs[3]  = mk(1, 0, 4'b1111, 0, 0, 4'b0100, 1, 3'd2, 2'd1);
    vecs[4]  = mk(1, 0, 4'b1111, 0, 0, 4'b1000, 1, 3'd3, 2'd1);
    vecs[5]  = mk(1, 0, 4'b1111, 0, 0, 4'b0001, 1, 3'd0, 2'd1);
    vecs[6]  = mk(1, 0, 4'b1111, 0, 0, 4'b0010, 1, 3'd1, 2'd1);
    vecs[7]  = mk(1, 0, 4'b1111, 0, 0, 4'b0100, 1, 3'd2, 2'd1);
    vecs[8]  = mk(1, 0, 4'b1111, 0, 0, 4'b1000, 1, 3'd3, 2'd1);
    vecs[9]  = mk(1, 0, 4'b0001, 0, 0, 4'b0001, 1, 3'd0, 2'd1);
    vecs[10] = mk(1, 0, 4'b1001, 0, 0, 4'b1000, 1, 3'd3, 2'd1);
    vecs[11] = mk(1, 0, 4'b1001, 0, 0, 4'b0001, 1, 3'd0, 2'd1);
    vecs[12] = mk(1, 0, 4'b1001, 0, 0, 4'b1000, 1, 3'd3, 2'd1);
    vecs[13] = mk(1, 0, 4'b0000, 0, 0, 4'b0000, 0, 3'd0, 2'd1);
    vecs[14] = mk(0, 0, 4'b0001, 0, 0, 4'b0001, 1, 3'd0, 2'd0);
    vecs[15] = mk(0, 0, 4'b0001, 0, 0, 4'b0000, 0, 3'd0, 2'd0);
    vecs[16] = mk(1, 0, 4'b0010, 0, 1, 4'b0000, 0, 3'd0, 2'd1);
    vecs[17] = mk(1, 0, 4'b0010, 0, 1, 4'b0000, 0, 3'd0, 2'd1);
    vecs[18] = mk(1, 0, 4'b0010, 0, 0, 4'b0010, 1, 3'd1, 2'd1);
    vecs[19] = mk(1, 0, 4'b0000, 1, 0, 4'b0000, 0, 3'd0, 2'd1);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      enable = vecs[i].en; drain = vecs[i].dr; src_valid = vecs[i].vld;
      fifo_almost_full = vecs[i].af; fifo_full = vecs[i].full;
      set_data(i);
      #1;
      chk($sformatf("tbl%0d_ready", i), 128'(src_ready), 128'(vecs[i].rdy));
      tick();
      chk($sformatf("tbl%0d_wr_en", i), 128'(fifo_wr_en), 128'(vecs[i].wr));
      chk($sformatf("tbl%0d_state", i), 128'(debug_state), 128'(vecs[i].st));
      chk($sformatf("tbl%0d_stall", i), 128'(stall_dut), 128'(0));
      if (vecs[i].wr) begin
        chk($sformatf("tbl%0d_wr_src", i), 128'(fifo_wr_src), 128'(vecs[i].src));
        chk($sformatf("tbl%0d_wr_data", i), fifo_wr_data, pat(int'(vecs[i].src), i));
      end
    end

    // ---------------- backpressure and minimum-length stall ----------------
    do_reset();
    enable = 1'b1;
    tick();
    hi_cnt = 0; wr_seen = 0; hs_cyc = -1; hs_tag = -1;
    for (int c = 0; c < 20; c++) begin
      fifo_almost_full = (c < 3);
      src_valid = (hs_cyc < 0) ? 4'b0001 : 4'b0000;
      set_data(100 + c);
      #1;
      if (c < 3) chk("bp_ready_blocked", 128'(src_ready), 128'(0));
      if (src_valid[0] && src_ready[0]) begin hs_cyc = c; hs_tag = 100 + c; end
      tick();
      if (stall_dut) hi_cnt++;
      if (c == 0) chk("bp_stall_rise", 128'(stall_dut), 128'(1));
      if (c == 9) chk("bp_stall_last_high", 128'(stall_dut), 128'(1));
      if (c == 10) chk("bp_stall_fall", 128'(stall_dut), 128'(0));
      if (fifo_wr_en) begin
        wr_seen++;
        chk("bp_wr_src", 128'(fifo_wr_src), 128'(0));
        chk("bp_wr_data", fifo_wr_data, pat(0, hs_tag));
      end
    end
    chk("bp_stall_len", 128'(hi_cnt), 128'(MS));
    chk("bp_hs_cycle", 128'(hs_cyc), 128'(3));
    chk("bp_write_count", 128'(wr_seen), 128'(1));

    // ---------------- drain: sticky, sinks everything ----------------
    do_reset();
    enable = 1'b1;
    tick();
    drain = 1'b1;
    tick();
    chk("drn_enter_state", 128'(debug_state), 128'(2));
    drain = 1'b0;
    for (int c = 0; c < 5; c++) begin
      src_valid = 4'b1111;
      fifo_full = (c == 2);
      fifo_almost_full = (c == 3);
      #1;
      chk($sformatf("drn%0d_ready", c), 128'(src_ready), 128'(4'b1111));
      tick();
      chk($sformatf("drn%0d_wr_en", c), 128'(fifo_wr_en), 128'(0));
      chk($sformatf("drn%0d_stall", c), 128'(stall_dut), 128'(0));
    end
    fifo_full = 1'b0; fifo_almost_full = 1'b0;
    chk("drn_drop_count", 128'(drop_count), 128'(20));
    chk("drn_state", 128'(debug_state), 128'(2));
    src_valid = '0; enable = 1'b0;
    tick();
    tick();
    chk("drn_sticky_state", 128'(debug_state), 128'(2));
    chk("drn_drop_hold", 128'(drop_count), 128'(20));

    // ---------------- drain coinciding with a handshake ----------------
    do_reset();
    enable = 1'b1;
    tick();
    src_valid = 4'b0001; set_data(200);
    tick();
    src_valid = 4'b0010; set_data(201); drain = 1'b1;
    #1;
    chk("dhs_ready", 128'(src_ready), 128'(4'b0010));
    chk("dhs_prev_wr_en", 128'(fifo_wr_en), 128'(1));
    chk("dhs_prev_wr_data", fifo_wr_data, pat(0, 200));
    tick();
    chk("dhs_no_write", 128'(fifo_wr_en), 128'(0));
    chk("dhs_state", 128'(debug_state), 128'(2));
    chk("dhs_drop", 128'(drop_count), 128'(1));
    drain = 1'b0; src_valid = '0;

    // ---------------- reset mid-stream ----------------
    do_reset();
    enable = 1'b1;
    tick();
    fifo_almost_full = 1'b1; src_valid = 4'b1111;
    tick();
    fifo_almost_full = 1'b0;
    for (int c = 0; c < 3; c++) begin set_data(300 + c); tick(); end
    chk("mrst_pre_wr_en", 128'(fifo_wr_en), 128'(1));
    chk("mrst_pre_stall", 128'(stall_dut), 128'(1));
    #2 reset = 1'b1;
    #1;
    chk("mrst_wr_en", 128'(fifo_wr_en), 128'(0));
    chk("mrst_stall", 128'(stall_dut), 128'(0));
    chk("mrst_wr_data", fifo_wr_data, 128'(0));
    chk("mrst_state", 128'(debug_state), 128'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    chk("mrst_idle_ready", 128'(src_ready), 128'(0));
    tick();
    chk("mrst_run", 128'(debug_state), 128'(1));
    #1;
    chk("mrst_first_grant", 128'(src_ready), 128'(4'b0001));
    tick();
    chk("mrst_first_wr_src", 128'(fifo_wr_src), 128'(0));
    chk("mrst_first_wr_en", 128'(fifo_wr_en), 128'(1));

`ifdef DIFFTEST_ARB_STATS_EN
    // ---------------- statistics counters ----------------
    do_reset();
    enable = 1'b1;
    tick();
    src_valid = 4'b0100;
    for (int c = 0; c < 6; c++) tick();
    src_valid = '0;
    tick();
    chk("stats_grant2", 128'(grant_count[2*32 +: 32]), 128'(6));
    chk("stats_grant0", 128'(grant_count[0 +: 32]), 128'(0));
    chk("stats_stall_cycles", 128'(stall_cycles), 128'(0));
`endif

    // ---------------- random traffic against the reference model ----------------
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      enable           = ($urandom % 16) != 0;
      src_valid        = N'($urandom);
      fifo_almost_full = ($urandom % 6) == 0;
      fifo_full        = ($urandom % 16) == 0;
      drain            = (c >= 2800) && (($urandom % 40) == 0);
      for (int w = 0; w < N*DW/32; w++) src_data[w*32 +: 32] = $urandom;
      #1;
      model_cycle(exp_rdy);
      chk($sformatf("rnd%0d_ready", c), 128'(src_ready), 128'(exp_rdy));
      tick();
      chk($sformatf("rnd%0d_wr_en", c), 128'(fifo_wr_en), 128'(m_wr));
      if (m_wr) begin
        chk($sformatf("rnd%0d_wr_src", c), 128'(fifo_wr_src), 128'(m_wr_src));
        chk($sformatf("rnd%0d_wr_data", c), fifo_wr_data, m_wr_dat);
      end
      chk($sformatf("rnd%0d_stall", c), 128'(stall_dut), 128'(m_stall));
      chk($sformatf("rnd%0d_state", c), 128'(debug_state), 128'(m_mode));
      chk($sformatf("rnd%0d_drop", c), 128'(drop_count), 128'(m_drop));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
